// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side hazard bus: hazard inputs from ID/EX and enable/flush/bubble outputs.
// The master drives the hazard inputs; the slave (the controller) drives the enables.
interface pipeline_hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   In_IDEX_MemRead;
    logic [4:0]             In_IDEX_RegRT;
    logic [4:0]             In_IFID_RegRS;
    logic [4:0]             In_IFID_RegRT;
    logic                   In_IFID_UsesRT;
    logic                   In_MultDivStart;
    logic                   In_BranchTaken;
    logic                   In_Halt;
    logic                   Out_PCWrite;
    logic                   Out_IFIDWrite;
    logic                   Out_IFIDFlush;
    logic                   Out_IDEXBubble;
    logic                   Out_Halted;
    logic [STALL_CNT_W-1:0] Out_StallCycles;

    modport master (
        output In_IDEX_MemRead, In_IDEX_RegRT, In_IFID_RegRS, In_IFID_RegRT,
               In_IFID_UsesRT, In_MultDivStart, In_BranchTaken, In_Halt,
        input  Out_PCWrite, Out_IFIDWrite, Out_IFIDFlush, Out_IDEXBubble,
               Out_Halted, Out_StallCycles
    );

    modport slave (
        input  In_IDEX_MemRead, In_IDEX_RegRT, In_IFID_RegRS, In_IFID_RegRT,
               In_IFID_UsesRT, In_MultDivStart, In_BranchTaken, In_Halt,
        output Out_PCWrite, Out_IFIDWrite, Out_IFIDFlush, Out_IDEXBubble,
               Out_Halted, Out_StallCycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubble, mult/div front-end hold, branch flush, sticky halt.
// Zero-cycle combinational response; stall/flush take effect at the next edge; no backpressure of its own.
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN,
        ST_MD_BUSY,
        ST_HALTED
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             md_cnt_q, md_cnt_d;
    logic                   halt_pend_q, halt_pend_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, halted;

    // $0 is hardwired, so a load targeting it can never create a dependency.
    assign lu = bus.In_IDEX_MemRead && (bus.In_IDEX_RegRT != 5'd0) &&
                ((bus.In_IDEX_RegRT == bus.In_IFID_RegRS) ||
                 (bus.In_IFID_UsesRT && (bus.In_IDEX_RegRT == bus.In_IFID_RegRT)));

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        halt_pend_d = halt_pend_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (lu) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (bus.In_Halt) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = ST_HALTED;
                end else if (bus.In_BranchTaken) begin
                    ifid_flush  = 1'b1;
                end else if (bus.In_MultDivStart) begin
                    state_d     = ST_MD_BUSY;
                    md_cnt_d    = 4'(MD_LATENCY - 1);
                end
            end
            ST_MD_BUSY: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                md_cnt_d    = md_cnt_q - 4'd1;
                halt_pend_d = halt_pend_q | bus.In_Halt;
                // Last busy cycle: a halt seen at any point during the op is honoured now.
                if (md_cnt_q == 4'd1) begin
                    state_d     = (halt_pend_q || bus.In_Halt) ? ST_HALTED : ST_RUN;
                    halt_pend_d = 1'b0;
                end
            end
            ST_HALTED: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                halted      = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (state_q != ST_HALTED) && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q     <= ST_RUN;
            md_cnt_q    <= 4'd0;
            halt_pend_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            halt_pend_q <= halt_pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset holds the front end frozen with a bubble regardless of state.
    assign bus.Out_PCWrite     = Reset_n & pc_write;
    assign bus.Out_IFIDWrite   = Reset_n & ifid_write;
    assign bus.Out_IFIDFlush   = Reset_n & ifid_flush;
    assign bus.Out_IDEXBubble  = ~Reset_n | idex_bubble;
    assign bus.Out_Halted      = Reset_n & halted;
    assign bus.Out_StallCycles = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench: stimulus pushes expected outputs into a queue, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;
    logic Clock;
    logic Reset_n;

    pipeline_hazard_ctrl_if #(.STALL_CNT_W(16)) hif ();

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .STALL_CNT_W(16)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (hif.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Expected output flags packed as {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Halted}.
    localparam logic [4:0] ADV = 5'b11000;
    localparam logic [4:0] FLS = 5'b11100;
    localparam logic [4:0] STL = 5'b00010;
    localparam logic [4:0] HLT = 5'b00011;

    logic [4:0]  exp_flags_q [$];
    logic [15:0] exp_cnt_q   [$];
    string       exp_name_q  [$];

    int checks   = 0;
    int failures = 0;
    bit stim_done = 1'b0;

    task automatic step(input logic rst_n, input logic mr, input logic [4:0] xrt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic md, input logic br, input logic hl,
                        input logic [4:0] e_flags, input logic [15:0] e_cnt, input string nm);
        @(posedge Clock);
        #1;
        Reset_n             = rst_n;
        hif.In_IDEX_MemRead = mr;
        hif.In_IDEX_RegRT   = xrt;
        hif.In_IFID_RegRS   = rs;
        hif.In_IFID_RegRT   = rt;
        hif.In_IFID_UsesRT  = ur;
        hif.In_MultDivStart = md;
        hif.In_BranchTaken  = br;
        hif.In_Halt         = hl;
        exp_flags_q.push_back(e_flags);
        exp_cnt_q.push_back(e_cnt);
        exp_name_q.push_back(nm);
    endtask

    task automatic idle(input logic [15:0] e_cnt, input string nm);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ADV, e_cnt, nm);
    endtask

    initial begin : monitor
        logic [4:0]  act_flags;
        logic [4:0]  e_flags;
        logic [15:0] e_cnt;
        string       nm;
        forever begin
            @(negedge Clock);
            if (exp_flags_q.size() > 0) begin
                e_flags   = exp_flags_q.pop_front();
                e_cnt     = exp_cnt_q.pop_front();
                nm        = exp_name_q.pop_front();
                act_flags = {hif.Out_PCWrite, hif.Out_IFIDWrite, hif.Out_IFIDFlush,
                             hif.Out_IDEXBubble, hif.Out_Halted};
                checks++;
                if (act_flags !== e_flags || hif.Out_StallCycles !== e_cnt) begin
                    failures++;
                    $display("FAIL %s: flags(pcw,ifw,fl,bub,hlt)=%b stall=%0d, required flags=%b stall=%0d",
                             nm, act_flags, hif.Out_StallCycles, e_flags, e_cnt);
                end
            end else if (stim_done) begin
                break;
            end
        end
    end

    initial begin : stimulus
        Reset_n             = 1'b0;
        hif.In_IDEX_MemRead = 1'b0;
        hif.In_IDEX_RegRT   = 5'd0;
        hif.In_IFID_RegRS   = 5'd0;
        hif.In_IFID_RegRT   = 5'd0;
        hif.In_IFID_UsesRT  = 1'b0;
        hif.In_MultDivStart = 1'b0;
        hif.In_BranchTaken  = 1'b0;
        hif.In_Halt         = 1'b0;
        repeat (2) @(posedge Clock);

        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, STL, 16'd0, "reset_state");
        idle(16'd0, "idle_after_reset");

        // load-use on RS: single bubble
        step(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, STL, 16'd0, "lu_rs");
        idle(16'd1, "lu_release");

        // $0 and RT gating
        step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ADV, 16'd1, "lu_reg0");
        step(1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, ADV, 16'd1, "rt_unused");
        step(1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, STL, 16'd1, "rt_used");
        idle(16'd2, "rt_release");

        // branch alone and branch under load-use
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FLS, 16'd2, "branch");
        step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STL, 16'd2, "branch_lu");
        step(1'b1, 1'b1, 5'd31, 5'd31, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, STL, 16'd3, "lu_r31");
        idle(16'd4, "lu_r31_release");

        // mult/div with halt in the second busy cycle
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, ADV, 16'd4, "md_start_h");
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STL, 16'd4, "md_h_busy1");
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, STL, 16'd5, "md_h_busy2");
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, STL, 16'd6, "md_h_busy3");
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 1'b1, i[0], i[1], 1'b0, HLT, 16'd7, "halted_hold");

        // reset out of HALTED
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, STL, 16'd7, "reset_halted");
        idle(16'd0, "run_after_reset");

        // plain mult/div: branch ignored, exactly 3 frozen cycles
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, ADV, 16'd0, "md_start");
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STL, 16'd0, "md_busy1");
        step(1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STL, 16'd1, "md_busy2");
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STL, 16'd2, "md_busy3");
        idle(16'd3, "md_done");

        // halt from RUN counts its entry cycle only
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, STL, 16'd3, "halt_entry");
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, HLT, 16'd4, "halt_run1");
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, HLT, 16'd4, "halt_run2");

        // reset mid-MD_BUSY
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, STL, 16'd4, "reset_halt2");
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, ADV, 16'd0, "md2_start");
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, STL, 16'd0, "md2_busy1");
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, STL, 16'd1, "reset_md");
        idle(16'd0, "run_after_md_reset");

        stim_done = 1'b1;
        repeat (3) @(posedge Clock);
        checks++;
        if (exp_flags_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: pending=%0d, required 0", exp_flags_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, required stimulus completion");
        $fatal(1);
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the IF/ID and ID/EX pipeline registers of the 5-stage MIPS pipeline.
- Detects load-use hazards and inserts one bubble per hazard.
- Holds the front end while a multi-cycle mult/div occupies EX.
- Flushes IF/ID on a taken branch, and enforces a sticky halt.
- Sits beside the decode stage. Its outputs drive the PC write enable, the IF/ID write/flush, and the ID/EX control-signal zeroing mux.

Parameters:
MD_LATENCY, 4, total EX-occupancy cycles of a mult/div instruction (legal range 2..15)
STALL_CNT_W, 16, width of the stall-cycle performance counter

Ports:
Clock  input  1  rising-edge clock
Reset_n  input  1  synchronous, active-low reset
In_IDEX_MemRead  input  1  instruction now in EX is a load
In_IDEX_RegRT  input  5  destination RT of that load
In_IFID_RegRS  input  5  RS of instruction in ID
In_IFID_RegRT  input  5  RT of instruction in ID
In_IFID_UsesRT  input  1  instruction in ID reads RT as a source
In_MultDivStart  input  1  instruction in ID is mult/div and will enter EX next edge
In_BranchTaken  input  1  branch in ID resolved taken this cycle
In_Halt  input  1  instruction in ID is halt
Out_PCWrite  output  1  PC register write enable
Out_IFIDWrite  output  1  IF/ID register write enable
Out_IFIDFlush  output  1  load NOP into IF/ID next edge
Out_IDEXBubble  output  1  zero the 32-bit control word entering ID/EX
Out_Halted  output  1  pipeline halted
Out_StallCycles  output  STALL_CNT_W  count of front-end stall cycles

Behaviour:
- States: RUN, MD_BUSY, HALTED. Registers: state, md_cnt[3:0], halt_pend, stall counter.
- Reset: Reset_n low at a rising edge sets state=RUN, md_cnt=0, halt_pend=0, Out_StallCycles=0.
- While Reset_n is low, outputs are forced to PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXBubble=1, Halted=0.
- Reset mid-MD_BUSY or mid-HALTED returns to RUN at that edge.
- Outputs are combinational from the current state and inputs. Zero-cycle response: a stall or flush takes effect at the next edge.
- Load-use hazard (lu):
  - lu = In_IDEX_MemRead && In_IDEX_RegRT!=0 && (RT==IFID_RS || (In_IFID_UsesRT && RT==IFID_RT)).
  - Register $0 never causes a hazard.
- RUN, priority order:
  1. lu: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0. Branch and mult/div start are suppressed and the ID instruction re-evaluates next cycle. State stays RUN.
  2. In_Halt: PCWrite=0, IFIDWrite=0, IDEXBubble=1. Next state is HALTED.
  3. In_BranchTaken: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXBubble=0.
  4. In_MultDivStart: normal advance (all enables 1, bubble 0). Next state is MD_BUSY with md_cnt=MD_LATENCY-1.
  5. Otherwise: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
- Simultaneous branch and mult/div start are illegal; branch wins.
- MD_BUSY:
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0.
  - md_cnt decrements each cycle. In_BranchTaken and lu are ignored.
  - In_Halt sets halt_pend.
  - When md_cnt==1 at an edge: next state is HALTED if halt_pend or In_Halt, else RUN. halt_pend clears.
  - Total front-end freeze is exactly MD_LATENCY-1 cycles after the start cycle.
- HALTED:
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1, Halted=1.
  - Sticky; only reset exits.
- Stall counter:
  - Increments on each edge where PCWrite==0 and the state is not HALTED and Reset_n is high. This includes lu and halt-entry cycles.
  - Saturates at all-ones; no wrap.
- Halt has no effect on instructions already past ID; they drain normally.

Test Plan:
- Load-use: MemRead=1, IDEX_RT=8, IFID_RS=8 -> exactly one cycle of PCWrite=0, IFIDWrite=0, IDEXBubble=1; next cycle (MemRead=0) all enables 1; StallCycles=1.
- $0 and RT gating: MemRead=1, IDEX_RT=0, IFID_RS=0 -> no stall. IDEX_RT=9, IFID_RT=9, UsesRT=0 -> no stall; with UsesRT=1 -> one-cycle stall.
- Mult/div, MD_LATENCY=4: MultDivStart pulse in RUN -> next 3 cycles PCWrite=0 with IDEXBubble=1 and BranchTaken ignored; 4th cycle back to RUN; StallCycles increases by 3.
- Branch vs hazard: BranchTaken=1 alone -> IFIDFlush=1, PCWrite=1. BranchTaken=1 with lu true -> IFIDFlush=0, stall asserted.
- Halt during mult/div: In_Halt=1 in 2nd MD_BUSY cycle -> after the countdown the state is HALTED with Out_Halted=1, held 20 cycles, and StallCycles frozen.
- Reset: Reset_n=0 for one edge while HALTED with StallCycles=7 -> RUN, StallCycles=0, PCWrite=1 on the first cycle after release.
